// File: rtl/ls_way_requester.sv
// ls_way_requester: sequences allocate/invalidate requests onto the LRU
// block's load/store port one at a time, decodes the one-hot way the LRU
// returns, and mirrors which ways of the set are allocated.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   alloc_req_i       allocate request (held until accepted)
//   inv_req_i         invalidate request (held until accepted), priority over allocate
//   inv_way_i         way to invalidate
//   req_ready_o       high in IDLE: a pending request is accepted this cycle
//   ls_valid_o        operation valid to LRU block (ISSUE cycle only)
//   ls_op_o           10 allocate, 11 invalidate, 00 idle
//   ls_way_o          way for invalidate, 0 otherwise
//   lru_valid_i       LRU allocate response valid (same cycle as ISSUE)
//   lru_way_i         LRU one-hot allocated/victim way
//   alloc_done_o      one-cycle allocate completion pulse
//   alloc_way_o       binary allocated way (with alloc_done_o)
//   alloc_evict_o     allocated way was already valid (victim)
//   alloc_err_o       LRU response missing, zero or not one-hot
//   inv_done_o        one-cycle invalidate completion pulse
//   valid_mask_o      mirror of allocated ways
//   full_o            all ways allocated
module ls_way_requester #(
  parameter  int unsigned NUM_WAYS = 4,
  localparam int unsigned W        = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_req_i,
  input  logic                inv_req_i,
  input  logic [W-1:0]        inv_way_i,
  output logic                req_ready_o,
  output logic                ls_valid_o,
  output logic [1:0]          ls_op_o,
  output logic [W-1:0]        ls_way_o,
  input  logic                lru_valid_i,
  input  logic [NUM_WAYS-1:0] lru_way_i,
  output logic                alloc_done_o,
  output logic [W-1:0]        alloc_way_o,
  output logic                alloc_evict_o,
  output logic                alloc_err_o,
  output logic                inv_done_o,
  output logic [NUM_WAYS-1:0] valid_mask_o,
  output logic                full_o
);

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_ALLOC = 2'b10;
  localparam logic [1:0] OP_INV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                op_inv_q, op_inv_d;
  logic [W-1:0]        way_q, way_d;

  logic                req_ready_d;
  logic                ls_valid_d;
  logic [1:0]          ls_op_d;
  logic [W-1:0]        ls_way_d;
  logic                alloc_done_d;
  logic [W-1:0]        alloc_way_d;
  logic                alloc_evict_d;
  logic                alloc_err_d;
  logic                inv_done_d;
  logic [NUM_WAYS-1:0] mask_d;

  logic [W-1:0]        lru_enc;
  logic                lru_onehot;

  // Binary encode of the LRU response; only meaningful when one-hot.
  always_comb begin
    lru_enc = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (lru_way_i[i]) lru_enc = W'(i);
    end
  end

  assign lru_onehot = (lru_way_i != '0) &&
                      ((lru_way_i & (lru_way_i - NUM_WAYS'(1))) == '0);

  // Next state and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    op_inv_d      = op_inv_q;
    way_d         = way_q;
    req_ready_d   = 1'b0;
    ls_valid_d    = 1'b0;
    ls_op_d       = OP_IDLE;
    ls_way_d      = '0;
    alloc_done_d  = 1'b0;
    alloc_way_d   = '0;
    alloc_evict_d = 1'b0;
    alloc_err_d   = 1'b0;
    inv_done_d    = 1'b0;
    mask_d        = valid_mask_o;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (inv_req_i) begin
          state_d     = ISSUE;
          op_inv_d    = 1'b1;
          way_d       = inv_way_i;
          req_ready_d = 1'b0;
          ls_valid_d  = 1'b1;
          ls_op_d     = OP_INV;
          ls_way_d    = inv_way_i;
        end else if (alloc_req_i) begin
          state_d     = ISSUE;
          op_inv_d    = 1'b0;
          way_d       = '0;
          req_ready_d = 1'b0;
          ls_valid_d  = 1'b1;
          ls_op_d     = OP_ALLOC;
        end
      end

      // LRU response is combinational, so it is judged during ISSUE.
      ISSUE: begin
        state_d = RESP;
        if (op_inv_q) begin
          inv_done_d = 1'b1;
        end else begin
          alloc_done_d = 1'b1;
          if (lru_valid_i && lru_onehot) begin
            alloc_way_d   = lru_enc;
            alloc_evict_d = valid_mask_o[lru_enc];
          end else begin
            alloc_err_d = 1'b1;
          end
        end
      end

      // Mirror commits at the edge ending RESP.
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        if (op_inv_q) begin
          mask_d[way_q] = 1'b0;
        end else if (!alloc_err_o) begin
          mask_d[alloc_way_o] = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      op_inv_q      <= 1'b0;
      way_q         <= '0;
      req_ready_o   <= 1'b1;
      ls_valid_o    <= 1'b0;
      ls_op_o       <= OP_IDLE;
      ls_way_o      <= '0;
      alloc_done_o  <= 1'b0;
      alloc_way_o   <= '0;
      alloc_evict_o <= 1'b0;
      alloc_err_o   <= 1'b0;
      inv_done_o    <= 1'b0;
      valid_mask_o  <= '0;
      full_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_inv_q      <= op_inv_d;
      way_q         <= way_d;
      req_ready_o   <= req_ready_d;
      ls_valid_o    <= ls_valid_d;
      ls_op_o       <= ls_op_d;
      ls_way_o      <= ls_way_d;
      alloc_done_o  <= alloc_done_d;
      alloc_way_o   <= alloc_way_d;
      alloc_evict_o <= alloc_evict_d;
      alloc_err_o   <= alloc_err_d;
      inv_done_o    <= inv_done_d;
      valid_mask_o  <= mask_d;
      full_o        <= &mask_d;
    end
  end

endmodule

// File: tb/tb_ls_way_requester.sv
// Directed bench for ls_way_requester (NUM_WAYS=4).
module tb_ls_way_requester;

  logic       clk;
  logic       reset;
  logic       alloc_req_i;
  logic       inv_req_i;
  logic [1:0] inv_way_i;
  logic       req_ready_o;
  logic       ls_valid_o;
  logic [1:0] ls_op_o;
  logic [1:0] ls_way_o;
  logic       lru_valid_i;
  logic [3:0] lru_way_i;
  logic       alloc_done_o;
  logic [1:0] alloc_way_o;
  logic       alloc_evict_o;
  logic       alloc_err_o;
  logic       inv_done_o;
  logic [3:0] valid_mask_o;
  logic       full_o;

  int vectors;
  int miscompares;

  ls_way_requester #(.NUM_WAYS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req_i  (alloc_req_i),
    .inv_req_i    (inv_req_i),
    .inv_way_i    (inv_way_i),
    .req_ready_o  (req_ready_o),
    .ls_valid_o   (ls_valid_o),
    .ls_op_o      (ls_op_o),
    .ls_way_o     (ls_way_o),
    .lru_valid_i  (lru_valid_i),
    .lru_way_i    (lru_way_i),
    .alloc_done_o (alloc_done_o),
    .alloc_way_o  (alloc_way_o),
    .alloc_evict_o(alloc_evict_o),
    .alloc_err_o  (alloc_err_o),
    .inv_done_o   (inv_done_o),
    .valid_mask_o (valid_mask_o),
    .full_o       (full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs that must hold in any IDLE cycle with no pulse.
  task automatic check_idle(input string tag, input logic [3:0] exp_mask);
    check({tag, ".ready"}, 32'(req_ready_o), 32'd1);
    check({tag, ".ls_valid"}, 32'(ls_valid_o), 32'd0);
    check({tag, ".ls_op"}, 32'(ls_op_o), 32'd0);
    check({tag, ".alloc_done"}, 32'(alloc_done_o), 32'd0);
    check({tag, ".inv_done"}, 32'(inv_done_o), 32'd0);
    check({tag, ".mask"}, 32'(valid_mask_o), 32'(exp_mask));
    check({tag, ".full"}, 32'(full_o), 32'(&exp_mask));
  endtask

  // One allocate from IDLE: ISSUE, RESP, back to IDLE in exactly 3 cycles.
  task automatic do_alloc(input string tag, input logic lv, input logic [3:0] lw,
                          input logic [1:0] exp_way, input logic exp_evict,
                          input logic exp_err, input logic [3:0] exp_mask);
    check({tag, ".pre_ready"}, 32'(req_ready_o), 32'd1);
    alloc_req_i = 1'b1;
    lru_valid_i = lv;
    lru_way_i   = lw;
    step();
    alloc_req_i = 1'b0;
    check({tag, ".issue_valid"}, 32'(ls_valid_o), 32'd1);
    check({tag, ".issue_op"}, 32'(ls_op_o), 32'h2);
    check({tag, ".issue_way"}, 32'(ls_way_o), 32'd0);
    check({tag, ".issue_ready"}, 32'(req_ready_o), 32'd0);
    step();
    check({tag, ".done"}, 32'(alloc_done_o), 32'd1);
    check({tag, ".way"}, 32'(alloc_way_o), 32'(exp_way));
    check({tag, ".evict"}, 32'(alloc_evict_o), 32'(exp_evict));
    check({tag, ".err"}, 32'(alloc_err_o), 32'(exp_err));
    check({tag, ".resp_op"}, 32'(ls_op_o), 32'd0);
    step();
    check_idle(tag, exp_mask);
    check({tag, ".idle_way"}, 32'(alloc_way_o), 32'd0);
    check({tag, ".idle_err"}, 32'(alloc_err_o), 32'd0);
  endtask

  task automatic do_inv(input string tag, input logic [1:0] way, input logic [3:0] exp_mask);
    inv_req_i = 1'b1;
    inv_way_i = way;
    step();
    inv_req_i = 1'b0;
    check({tag, ".issue_valid"}, 32'(ls_valid_o), 32'd1);
    check({tag, ".issue_op"}, 32'(ls_op_o), 32'h3);
    check({tag, ".issue_way"}, 32'(ls_way_o), 32'(way));
    step();
    check({tag, ".done"}, 32'(inv_done_o), 32'd1);
    check({tag, ".no_alloc_done"}, 32'(alloc_done_o), 32'd0);
    step();
    check_idle(tag, exp_mask);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    alloc_req_i = 1'b0;
    inv_req_i   = 1'b0;
    inv_way_i   = 2'd0;
    lru_valid_i = 1'b0;
    lru_way_i   = 4'b0000;

    // Reset
    step();
    step();
    check_idle("rst", 4'b0000);
    #2 reset = 1'b1;
    step();
    check_idle("rst_rel", 4'b0000);

    // Fill the set
    do_alloc("fill0", 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0, 4'b0001);
    do_alloc("fill1", 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0, 4'b0011);
    do_alloc("fill2", 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b0111);
    do_alloc("fill3", 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0, 4'b1111);

    // Victim on a full set
    do_alloc("victim", 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b1111);

    // Invalidate way 2, then reallocate it
    do_inv("inv2", 2'd2, 4'b1011);
    do_alloc("realloc2", 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0, 4'b1111);

    // Simultaneous requests: invalidate first, allocate 3 cycles later
    alloc_req_i = 1'b1;
    inv_req_i   = 1'b1;
    inv_way_i   = 2'd1;
    lru_valid_i = 1'b1;
    lru_way_i   = 4'b0010;
    step();
    inv_req_i = 1'b0;
    check("sim.issue_op", 32'(ls_op_o), 32'h3);
    check("sim.issue_way", 32'(ls_way_o), 32'd1);
    step();
    check("sim.inv_done", 32'(inv_done_o), 32'd1);
    step();
    check("sim.ready", 32'(req_ready_o), 32'd1);
    check("sim.mask_mid", 32'(valid_mask_o), 32'hd);
    check("sim.full_mid", 32'(full_o), 32'd0);
    step();
    alloc_req_i = 1'b0;
    check("sim.alloc_op", 32'(ls_op_o), 32'h2);
    step();
    check("sim.alloc_done", 32'(alloc_done_o), 32'd1);
    check("sim.alloc_way", 32'(alloc_way_o), 32'd1);
    check("sim.alloc_evict", 32'(alloc_evict_o), 32'd0);
    step();
    check_idle("sim.end", 4'b1111);

    // Error responses leave the mirror untouched
    do_inv("inv3", 2'd3, 4'b0111);
    do_alloc("err_novalid", 1'b0, 4'b1000, 2'd0, 1'b0, 1'b1, 4'b0111);
    do_alloc("err_multi", 1'b1, 4'b1100, 2'd0, 1'b0, 1'b1, 4'b0111);
    do_alloc("err_zero", 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 4'b0111);

    // Invalidate of an already-clear way is a no-op
    do_inv("inv3_again", 2'd3, 4'b0111);

    // Reset asserted during ISSUE
    alloc_req_i = 1'b1;
    lru_valid_i = 1'b1;
    lru_way_i   = 4'b1000;
    step();
    alloc_req_i = 1'b0;
    check("rst_mid.issue_valid", 32'(ls_valid_o), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid.ls_valid", 32'(ls_valid_o), 32'd0);
    check("rst_mid.ready", 32'(req_ready_o), 32'd1);
    check("rst_mid.mask", 32'(valid_mask_o), 32'd0);
    #2 reset = 1'b1;
    step();
    check_idle("rst_mid.after", 4'b0000);
    check("rst_mid.no_err", 32'(alloc_err_o), 32'd0);
    step();
    check_idle("rst_mid.after2", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
